// File: rtl/bbox_sample_iterator_pkg.sv
// Shared raster definitions for the bounding-box sample iterator.
package bbox_sample_iterator_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } iter_state_t;

    localparam int LL = 0;
    localparam int UR = 1;

    // One-hot rate select to sample spacing; anything not one-hot means one sample per pixel.
    function automatic int ss_step(input logic [3:0] sub_sample, input int radix);
        int k;
        case (sub_sample)
            4'b1000: k = 0;
            4'b0100: k = 1;
            4'b0010: k = 2;
            4'b0001: k = 3;
            default: k = 0;
        endcase
        return 1 << (radix - k);
    endfunction

endpackage

// File: rtl/bbox_sample_iterator_sample_stepper.sv
// Raster-order x/y advance and last-sample detection for one bounding box.
module sample_stepper #(
    parameter int SIGFIG = 24
) (
    input  logic signed [SIGFIG-1:0] sample_x,
    input  logic signed [SIGFIG-1:0] sample_y,
    input  logic signed [SIGFIG-1:0] ll_x,
    input  logic signed [SIGFIG-1:0] ur_x,
    input  logic signed [SIGFIG-1:0] ur_y,
    input  logic signed [SIGFIG-1:0] step,
    output logic signed [SIGFIG-1:0] next_x,
    output logic signed [SIGFIG-1:0] next_y,
    output logic                     last
);
    // x runs fastest; wrap to the left edge and move up one row at the right edge
    always_comb begin
        next_x = sample_x;
        next_y = sample_y;
        last   = 1'b0;
        if ((sample_x >= ur_x) && (sample_y >= ur_y)) begin
            last = 1'b1;
        end else if (sample_x >= ur_x) begin
            next_x = ll_x;
            next_y = sample_y + step;
        end else begin
            next_x = sample_x + step;
        end
    end
endmodule

// File: rtl/dff.sv
// Standard flop modules: dff for a packed vector, dff2 for a signed 2-D array.
module dff #(
    parameter int WIDTH         = 1,
    parameter int RETIME_STATUS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Retimable flops carry no reset so synthesis is free to move them.
    if (RETIME_STATUS == 0) begin : g_rst
        // Resettable storage
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= {WIDTH{1'b0}};
            end else begin
                q <= d;
            end
        end
    end else begin : g_norst
        // Reset-free storage
        always_ff @(posedge clk) begin
            q <= d;
        end
    end
endmodule

module dff2 #(
    parameter int WIDTH         = 1,
    parameter int ARRAY_SIZE1   = 1,
    parameter int ARRAY_SIZE2   = 1,
    parameter int RETIME_STATUS = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] d [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0],
    output logic signed [WIDTH-1:0] q [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0]
);
    // Array storage; reset only when not retimable
    always_ff @(posedge clk) begin
        for (int i = 0; i < ARRAY_SIZE1; i++) begin
            for (int j = 0; j < ARRAY_SIZE2; j++) begin
                if (rst && (RETIME_STATUS == 0)) begin
                    q[i][j] <= {WIDTH{1'b0}};
                end else begin
                    q[i][j] <= d[i][j];
                end
            end
        end
    end
endmodule

// File: rtl/bbox_sample_iterator.sv
// Iterates every sample in a triangle's bounding box, one per cycle, holding
// the upstream bbox stage off while a triangle is in flight.
module bbox_sample_iterator
    import bbox_sample_iterator_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R14S [VERTS-1:0][AXIS-1:0],
    input  logic        [SIGFIG-1:0] color_R14U [COLORS-1:0],
    input  logic signed [SIGFIG-1:0] box_R14S [1:0][1:0],
    input  logic                     validTri_R14H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R16S [VERTS-1:0][AXIS-1:0],
    output logic        [SIGFIG-1:0] color_R16U [COLORS-1:0],
    output logic signed [SIGFIG-1:0] sample_R16S [1:0],
    output logic                     validSamp_R16H
);

    iter_state_t state_q, state_d;
    logic               accept_s;
    logic               last_s;
    logic signed [SIGFIG-1:0] next_x_s, next_y_s;
    logic signed [SIGFIG-1:0] ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
    logic signed [SIGFIG-1:0] step_q, step_d;
    logic signed [SIGFIG-1:0] sample_d [1:0];
    logic signed [SIGFIG-1:0] tri_d [VERTS-1:0][AXIS-1:0];
    logic        [SIGFIG-1:0] color_d [COLORS-1:0];

    assign accept_s       = (state_q == WAIT) && validTri_R14H;
    assign halt_RnnnnL    = (state_q == WAIT);
    assign validSamp_R16H = (state_q == TEST);

    sample_stepper #(.SIGFIG(SIGFIG)) u_stepper (
        .sample_x (sample_R16S[0]),
        .sample_y (sample_R16S[1]),
        .ll_x     (ll_x_q),
        .ur_x     (ur_x_q),
        .ur_y     (ur_y_q),
        .step     (step_q),
        .next_x   (next_x_s),
        .next_y   (next_y_s),
        .last     (last_s)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT: begin
                if (validTri_R14H) begin
                    state_d = TEST;
                end else begin
                    state_d = WAIT;
                end
            end
            TEST: begin
                if (last_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = TEST;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Triangle latch at accept, sample advance while testing
    always_comb begin
        tri_d       = tri_R16S;
        color_d     = color_R16U;
        ll_x_d      = ll_x_q;
        ur_x_d      = ur_x_q;
        ur_y_d      = ur_y_q;
        step_d      = step_q;
        sample_d[0] = sample_R16S[0];
        sample_d[1] = sample_R16S[1];
        if (accept_s) begin
            tri_d       = tri_R14S;
            color_d     = color_R14U;
            ll_x_d      = box_R14S[LL][0];
            ur_x_d      = box_R14S[UR][0];
            ur_y_d      = box_R14S[UR][1];
            step_d      = SIGFIG'(ss_step(subSample_RnnnnU, RADIX));
            sample_d[0] = box_R14S[LL][0];
            sample_d[1] = box_R14S[LL][1];
        end else if (state_q == TEST) begin
            sample_d[0] = next_x_s;
            sample_d[1] = next_y_s;
        end else begin
            sample_d[0] = sample_R16S[0];
            sample_d[1] = sample_R16S[1];
        end
    end

    // Latched box edges and step for the triangle in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            ll_x_q <= {SIGFIG{1'b0}};
            ur_x_q <= {SIGFIG{1'b0}};
            ur_y_q <= {SIGFIG{1'b0}};
            step_q <= {SIGFIG{1'b0}};
        end else begin
            ll_x_q <= ll_x_d;
            ur_x_q <= ur_x_d;
            ur_y_q <= ur_y_d;
            step_q <= step_d;
        end
    end

    dff2 #(
        .WIDTH(SIGFIG), .ARRAY_SIZE1(VERTS), .ARRAY_SIZE2(AXIS), .RETIME_STATUS(0)
    ) u_tri (
        .clk (clk),
        .rst (rst),
        .d   (tri_d),
        .q   (tri_R16S)
    );

    for (genvar c = 0; c < COLORS; c++) begin : g_color
        dff #(.WIDTH(SIGFIG), .RETIME_STATUS(0)) u_color (
            .clk (clk),
            .rst (rst),
            .d   (color_d[c]),
            .q   (color_R16U[c])
        );
    end

    for (genvar s = 0; s < 2; s++) begin : g_sample
        dff #(.WIDTH(SIGFIG), .RETIME_STATUS(0)) u_sample (
            .clk (clk),
            .rst (rst),
            .d   (sample_d[s]),
            .q   (sample_R16S[s])
        );
    end

endmodule

// File: tb/tb_bbox_sample_iterator.sv
// Randomized self-checking bench: expected sample lists are enumerated from the box and rate.
module tb_bbox_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [SIGFIG-1:0] tri_in [2:0][2:0];
    logic        [SIGFIG-1:0] color_in [2:0];
    logic signed [SIGFIG-1:0] box_in [1:0][1:0];
    logic                     valid_in = 1'b0;
    logic        [3:0]        ss_in = 4'b1000;
    logic                     halt_out;
    logic signed [SIGFIG-1:0] tri_out [2:0][2:0];
    logic        [SIGFIG-1:0] color_out [2:0];
    logic signed [SIGFIG-1:0] sample_out [1:0];
    logic                     valid_out;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_x [$];
    int exp_y [$];
    logic signed [SIGFIG-1:0] exp_tri [2:0][2:0];
    logic        [SIGFIG-1:0] exp_color [2:0];

    bbox_sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R14S         (tri_in),
        .color_R14U       (color_in),
        .box_R14S         (box_in),
        .validTri_R14H    (valid_in),
        .subSample_RnnnnU (ss_in),
        .halt_RnnnnL      (halt_out),
        .tri_R16S         (tri_out),
        .color_R16U       (color_out),
        .sample_R16S      (sample_out),
        .validSamp_R16H   (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int rate_to_step(input logic [3:0] ss);
        if (ss == 4'b0100) return 512;
        if (ss == 4'b0010) return 256;
        if (ss == 4'b0001) return 128;
        return 1024;
    endfunction

    // Present a triangle (call only in a WAIT cycle) and enumerate its samples.
    task automatic present(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] ss);
        int st;
        check_eq("halt_before_accept", longint'(halt_out), 1);
        for (int v = 0; v < 3; v++) begin
            for (int a = 0; a < 3; a++) begin
                tri_in[v][a]  = 24'($urandom);
                exp_tri[v][a] = tri_in[v][a];
            end
            color_in[v]  = 24'($urandom);
            exp_color[v] = color_in[v];
        end
        box_in[0][0] = 24'(llx);
        box_in[0][1] = 24'(lly);
        box_in[1][0] = 24'(urx);
        box_in[1][1] = 24'(ury);
        ss_in    = ss;
        valid_in = 1'b1;
        st = rate_to_step(ss);
        exp_x.delete();
        exp_y.delete();
        for (int y = lly; y <= ury; y += st) begin
            for (int x = llx; x <= urx; x += st) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
        end
    endtask

    task automatic check_sample(input int i);
        check_eq("valid_in_test", longint'(valid_out), 1);
        check_eq("halt_in_test", longint'(halt_out), 0);
        check_eq("sample_x", longint'(sample_out[0]), longint'(exp_x[i]));
        check_eq("sample_y", longint'(sample_out[1]), longint'(exp_y[i]));
        for (int v = 0; v < 3; v++) begin
            for (int a = 0; a < 3; a++) begin
                check_eq("tri", longint'(tri_out[v][a]), longint'(exp_tri[v][a]));
            end
            check_eq("color", longint'(color_out[v]), longint'(exp_color[v]));
        end
    endtask

    // Walk all expected samples, then check the single WAIT gap cycle.
    task automatic iterate(input bit hold_valid);
        @(posedge clk);
        #1;
        if (!hold_valid) valid_in = 1'b0;
        for (int i = 0; i < exp_x.size(); i++) begin
            check_sample(i);
            @(posedge clk);
            #1;
        end
        check_eq("gap_valid", longint'(valid_out), 0);
        check_eq("gap_halt", longint'(halt_out), 1);
    endtask

    initial begin
        for (int v = 0; v < 3; v++) begin
            for (int a = 0; a < 3; a++) tri_in[v][a] = 24'sd0;
            color_in[v] = 24'd0;
        end
        for (int c = 0; c < 2; c++) begin
            box_in[c][0] = 24'sd0;
            box_in[c][1] = 24'sd0;
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_halt", longint'(halt_out), 1);
        check_eq("rst_valid", longint'(valid_out), 0);
        check_eq("rst_sx", longint'(sample_out[0]), 0);
        check_eq("rst_sy", longint'(sample_out[1]), 0);
        check_eq("rst_tri", longint'(tri_out[1][2]), 0);
        check_eq("rst_color", longint'(color_out[2]), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_halt", longint'(halt_out), 1);
        check_eq("idle_valid", longint'(valid_out), 0);

        present(0, 0, 2048, 1024, 4'b1000);
        check_eq("plan_3x2_count", longint'(exp_x.size()), 6);
        iterate(1'b0);
        present(1024, 1024, 1536, 1536, 4'b0100);
        check_eq("plan_msaa4_count", longint'(exp_x.size()), 4);
        iterate(1'b0);
        present(3072, 2048, 3072, 2048, 4'b0010);
        iterate(1'b0);
        present(-256, -128, -128, -128, 4'b0001);
        iterate(1'b0);
        present(0, 0, 1024, 0, 4'b0110);
        iterate(1'b0);

        // Back-to-back: valid stays high, second triangle presented in the gap cycle
        present(0, 0, 1024, 1024, 4'b1000);
        iterate(1'b1);
        present(512, 0, 1024, 512, 4'b0100);
        iterate(1'b0);

        // Reset during the third sample of the 3x2 box
        present(0, 0, 2048, 1024, 4'b1000);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_sample(i);
            if (i == 2) begin
                rst = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check_eq("midrst_valid", longint'(valid_out), 0);
        check_eq("midrst_halt", longint'(halt_out), 1);
        check_eq("midrst_sx", longint'(sample_out[0]), 0);
        @(posedge clk);
        #1;
        check_eq("post_rst_idle", longint'(valid_out), 0);
        present(-1024, 2048, 0, 3072, 4'b1000);
        iterate(1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [3:0] ss;
            int st, nx, ny, llx, lly;
            case ($urandom_range(0, 4))
                0: ss = 4'b1000;
                1: ss = 4'b0100;
                2: ss = 4'b0010;
                3: ss = 4'b0001;
                default: ss = 4'($urandom);
            endcase
            st  = rate_to_step(ss);
            nx  = int'($urandom_range(1, 4));
            ny  = int'($urandom_range(1, 4));
            llx = (int'($urandom_range(0, 64)) - 32) * st;
            lly = (int'($urandom_range(0, 64)) - 32) * st;
            present(llx, lly, llx + (nx - 1) * st, lly + (ny - 1) * st, ss);
            iterate(($urandom_range(0, 1) == 1) && (t < 29));
        end
        valid_in = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
